// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. Produces
//               latch write-enables and bubble-inserts for PC/FD/DX/XM/MW,
//               detects load-use hazards, runs the multdiv handshake and
//               squashes wrong-path instructions on a taken branch/jump.
// Revision    : 1.0 - initial release
//============================================================================
module pipe_hazard_ctrl #(
    parameter logic [31:0] ISA_NOP = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_insn,
    input  logic [31:0]      dx_insn,
    input  logic             br_taken,
    input  logic             md_ready,
    input  logic             md_except,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_bubble,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_is_div,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Opcode / ALU-op encodings used by the hazard decode
    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_ADDI  = 5'b00101;
    localparam logic [4:0] c_OP_LW    = 5'b01000;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_ALU_MUL  = 5'b00110;
    localparam logic [4:0] c_ALU_DIV  = 5'b00111;

    // Multdiv sequencer states
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    // Field extraction
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
    logic [4:0] w_dx_op, w_dx_rd, w_dx_aluop;

    assign w_fd_op    = fd_insn[31:27];
    assign w_fd_rd    = fd_insn[26:22];
    assign w_fd_rs    = fd_insn[21:17];
    assign w_fd_rt    = fd_insn[16:12];
    assign w_dx_op    = dx_insn[31:27];
    assign w_dx_rd    = dx_insn[26:22];
    assign w_dx_aluop = dx_insn[6:2];

    // Mul/div currently sitting in DX
    logic w_dx_mul, w_dx_div, w_dx_md;

    assign w_dx_mul = (w_dx_op == c_OP_RTYPE) && (w_dx_aluop == c_ALU_MUL);
    assign w_dx_div = (w_dx_op == c_OP_RTYPE) && (w_dx_aluop == c_ALU_DIV);
    assign w_dx_md  = w_dx_mul || w_dx_div;

    // Which FD fields are read as source registers for this opcode
    logic w_use_rd, w_use_rs, w_use_rt;

    // Source-register usage decode for the instruction in FD
    always_comb begin
        w_use_rd = 1'b0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        case (w_fd_op)
            c_OP_RTYPE: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            c_OP_ADDI, c_OP_LW: begin
                w_use_rs = 1'b1;
            end
            c_OP_SW, c_OP_BNE, c_OP_BLT: begin
                w_use_rd = 1'b1;
                w_use_rs = 1'b1;
            end
            c_OP_JR: begin
                w_use_rd = 1'b1;
            end
            default: begin
                w_use_rd = 1'b0;
                w_use_rs = 1'b0;
                w_use_rt = 1'b0;
            end
        endcase
    end

    // Load-use: a load in DX writes a register FD is about to read.
    // r0 is hardwired to zero so a load targeting it never conflicts.
    logic w_lu;

    assign w_lu = (w_dx_op == c_OP_LW) && (w_dx_rd != 5'd0) &&
                  ((w_use_rd && (w_fd_rd == w_dx_rd)) ||
                   (w_use_rs && (w_fd_rs == w_dx_rd)) ||
                   (w_use_rt && (w_fd_rt == w_dx_rd)));

    // Multdiv sequencer: start on a mul/div in DX, release on md_ready.
    // md_ready seen while idle (e.g. after a reset mid-operation) is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (w_dx_md)  r_state <= MD_BUSY;
                MD_BUSY: if (md_ready) r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    // Enable / bubble / start generation, combinational from state and inputs
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        xm_en     = 1'b1;
        mw_en     = 1'b1;
        fd_bubble = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_start  = 1'b0;
        if (!reset) begin
            if (r_state == MD_BUSY) begin
                // Hold the mul/div in DX until its result is ready; the
                // release cycle lets it advance into XM with everything open.
                if (!md_ready) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_bubble = 1'b1;
                end
            end else if (w_dx_md) begin
                // Kick off the operation and freeze the front end this cycle
                md_start  = 1'b1;
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_bubble = 1'b1;
            end else if (br_taken) begin
                // Both younger instructions are on the wrong path
                fd_bubble = 1'b1;
                dx_bubble = 1'b1;
            end else if (w_lu) begin
                // Hold PC/FD one cycle and let a bubble follow the load
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_bubble = 1'b1;
            end
        end
    end

    // md_is_div only has meaning alongside md_start
    assign md_is_div = w_dx_div;
    assign md_busy   = (r_state == MD_BUSY) && !reset;

    // Saturating count of front-end stall cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

    // Fields and inputs this block deliberately does not consume: the
    // exception flag is handled in the datapath, and the bubble word is
    // substituted by the latches themselves.
    logic w_unused;
    assign w_unused = &{1'b0, md_except, fd_insn[11:0], dx_insn[21:7],
                        dx_insn[1:0], ISA_NOP};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. A rule-level model
//               is compared against the DUT every cycle; directed scenarios
//               add hand-computed literal checks.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_insn, dx_insn;
    logic        br_taken, md_ready, md_except;

    logic        pc_en, fd_en, dx_en, xm_en, mw_en;
    logic        fd_bubble, dx_bubble, xm_bubble;
    logic        md_start, md_is_div, md_busy;
    logic [31:0] stall_cnt;

    // Second instance with a 3-bit counter to reach saturation quickly
    logic        pc_en3, fd_en3, dx_en3, xm_en3, mw_en3;
    logic        fd_bubble3, dx_bubble3, xm_bubble3;
    logic        md_start3, md_is_div3, md_busy3;
    logic [2:0]  stall_cnt3;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.ISA_NOP(32'h0), .CNT_W(32)) u_dut (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .br_taken(br_taken), .md_ready(md_ready), .md_except(md_except),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en),
        .mw_en(mw_en), .fd_bubble(fd_bubble), .dx_bubble(dx_bubble),
        .xm_bubble(xm_bubble), .md_start(md_start), .md_is_div(md_is_div),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.ISA_NOP(32'h0), .CNT_W(3)) u_dut3 (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .br_taken(br_taken), .md_ready(md_ready), .md_except(md_except),
        .pc_en(pc_en3), .fd_en(fd_en3), .dx_en(dx_en3), .xm_en(xm_en3),
        .mw_en(mw_en3), .fd_bubble(fd_bubble3), .dx_bubble(dx_bubble3),
        .xm_bubble(xm_bubble3), .md_start(md_start3), .md_is_div(md_is_div3),
        .md_busy(md_busy3), .stall_cnt(stall_cnt3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] aluop);
        return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    localparam logic [31:0] NOP = 32'h0;

    // ---------------- rule-level model ----------------
    typedef struct packed {
        logic pc, fd, dx, xm, mw, fdb, dxb, xmb, start, isdiv, busy;
    } exp_t;

    // Registers read by an FD instruction; 0 stands for "no source" since
    // r0 can never conflict anyway.
    function automatic logic [14:0] srcs_of(input logic [31:0] w);
        logic [4:0] rd, rs, rt;
        rd = w[26:22]; rs = w[21:17]; rt = w[16:12];
        case (w[31:27])
            5'b00000:                   return {rs, rt, 5'd0};
            5'b00101, 5'b01000:         return {rs, 5'd0, 5'd0};
            5'b00111, 5'b00010, 5'b00110: return {rd, rs, 5'd0};
            5'b00100:                   return {rd, 5'd0, 5'd0};
            default:                    return 15'd0;
        endcase
    endfunction

    function automatic logic load_use(input logic [31:0] fd, input logic [31:0] dx);
        logic [14:0] s;
        logic [4:0]  d;
        if (dx[31:27] != 5'b01000) return 1'b0;
        d = dx[26:22];
        if (d == 5'd0) return 1'b0;
        s = srcs_of(fd);
        for (int i = 0; i < 3; i++)
            if (s[i*5 +: 5] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic rst, input logic inflight,
                                   input logic [31:0] fd, input logic [31:0] dx,
                                   input logic br, input logic rdy);
        exp_t e;
        logic is_mul, is_div;
        is_mul = (dx[31:27] == 5'd0) && (dx[6:2] == 5'b00110);
        is_div = (dx[31:27] == 5'd0) && (dx[6:2] == 5'b00111);
        // baseline: everything flows
        e = '{pc:1, fd:1, dx:1, xm:1, mw:1, fdb:0, dxb:0, xmb:0, start:0, isdiv:0, busy:0};
        e.isdiv = is_div;
        if (rst) return e;
        e.busy = inflight;
        if ((inflight && !rdy) || (!inflight && (is_mul || is_div))) begin
            e.pc = 0; e.fd = 0; e.dx = 0; e.xmb = 1;
            e.start = !inflight;
        end else if (!inflight && br) begin
            e.fdb = 1; e.dxb = 1;
        end else if (!inflight && load_use(fd, dx)) begin
            e.pc = 0; e.fd = 0; e.dxb = 1;
        end
        return e;
    endfunction

    logic        m_valid = 1'b0;
    logic        m_inflight = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    logic [2:0]  m_cnt3 = 3'd0;

    // Advance the model's architectural state at each edge
    always @(posedge clock) begin
        exp_t e;
        e = model(reset, m_inflight, fd_insn, dx_insn, br_taken, md_ready);
        if (reset) begin
            m_valid    <= 1'b1;
            m_inflight <= 1'b0;
            m_cnt      <= 32'd0;
            m_cnt3     <= 3'd0;
        end else begin
            m_inflight <= e.start || (m_inflight && !md_ready);
            if (!e.pc) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
                if (m_cnt3 != 3'd7)         m_cnt3 <= m_cnt3 + 3'd1;
            end
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clock) begin
        exp_t e;
        if (m_valid) begin
            e = model(reset, m_inflight, fd_insn, dx_insn, br_taken, md_ready);
            check("pc_en",     {31'd0, pc_en},     {31'd0, e.pc});
            check("fd_en",     {31'd0, fd_en},     {31'd0, e.fd});
            check("dx_en",     {31'd0, dx_en},     {31'd0, e.dx});
            check("xm_en",     {31'd0, xm_en},     {31'd0, e.xm});
            check("mw_en",     {31'd0, mw_en},     {31'd0, e.mw});
            check("fd_bubble", {31'd0, fd_bubble}, {31'd0, e.fdb});
            check("dx_bubble", {31'd0, dx_bubble}, {31'd0, e.dxb});
            check("xm_bubble", {31'd0, xm_bubble}, {31'd0, e.xmb});
            check("md_start",  {31'd0, md_start},  {31'd0, e.start});
            check("md_busy",   {31'd0, md_busy},   {31'd0, e.busy});
            if (e.start) check("md_is_div", {31'd0, md_is_div}, {31'd0, e.isdiv});
            check("stall_cnt",  stall_cnt,         m_cnt);
            check("stall_cnt3", {29'd0, stall_cnt3}, {29'd0, m_cnt3});
            check("pc_en3",     {31'd0, pc_en3},   {31'd0, e.pc});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive inputs shortly after an edge and let combinational outputs settle
    task automatic apply(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                         input logic br, input logic rdy);
        reset = rst; fd_insn = fd; dx_insn = dx; br_taken = br;
        md_ready = rdy; md_except = rdy & dx[2];
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        stall;
        string       name;
    } hz_vec_t;

    logic [31:0] w_mul, w_div, w_lw5, w_add351;
    int n_start, n_wait, n_xmb, n_stall;
    hz_vec_t hz [9];

    initial begin
        w_mul    = enc(5'b00000, 5'd4, 5'd2, 5'd3, 5'b00110);
        w_div    = enc(5'b00000, 5'd4, 5'd2, 5'd3, 5'b00111);
        w_lw5    = enc(5'b01000, 5'd5, 5'd2, 5'd0, 5'd0);
        w_add351 = enc(5'b00000, 5'd3, 5'd5, 5'd1, 5'd0);

        hz[0] = '{enc(5'b00000, 5'd3, 5'd0, 5'd0, 5'd0), enc(5'b01000, 5'd0, 5'd2, 5'd0, 5'd0), 1'b0, "lw_r0"};
        hz[1] = '{enc(5'b00101, 5'd6, 5'd7, 5'd0, 5'd1), w_lw5, 1'b0, "addi_r7"};
        hz[2] = '{enc(5'b00111, 5'd5, 5'd9, 5'd0, 5'd0), w_lw5, 1'b1, "sw_rd"};
        hz[3] = '{enc(5'b00100, 5'd5, 5'd0, 5'd0, 5'd0), w_lw5, 1'b1, "jr_rd"};
        hz[4] = '{enc(5'b00001, 5'd5, 5'd5, 5'd5, 5'd0), w_lw5, 1'b0, "j_nosrc"};
        hz[5] = '{enc(5'b00000, 5'd3, 5'd1, 5'd5, 5'd0), w_lw5, 1'b1, "rtype_rt"};
        hz[6] = '{enc(5'b00101, 5'd5, 5'd6, 5'd0, 5'd0), w_lw5, 1'b0, "addi_dest"};
        hz[7] = '{enc(5'b00010, 5'd1, 5'd5, 5'd0, 5'd0), w_lw5, 1'b1, "bne_rs"};
        hz[8] = '{w_add351, enc(5'b00101, 5'd5, 5'd2, 5'd0, 5'd0), 1'b0, "dx_not_load"};

        // Reset held two cycles with a mul in DX
        apply(1'b1, NOP, w_mul, 1'b0, 1'b0);
        check("rst_md_start", {31'd0, md_start}, 32'd0);
        check("rst_enables",  {27'd0, pc_en, fd_en, dx_en, xm_en, mw_en}, 32'h1F);
        check("rst_busy",     {31'd0, md_busy}, 32'd0);
        tick();
        apply(1'b1, NOP, w_mul, 1'b0, 1'b0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_md_start2", {31'd0, md_start}, 32'd0);
        tick();

        // Load-use: lw r5 in DX, add r3,r5,r1 in FD
        apply(1'b0, w_add351, w_lw5, 1'b0, 1'b0);
        check("lu_stall", {29'd0, pc_en, fd_en, dx_bubble}, 32'b001);
        tick();
        apply(1'b0, w_add351, NOP, 1'b0, 1'b0);
        check("lu_release", {29'd0, pc_en, fd_en, dx_bubble}, 32'b110);
        check("lu_cnt", stall_cnt, 32'd1);
        tick();

        // Source-field coverage and false-hazard cases
        foreach (hz[i]) begin
            apply(1'b0, hz[i].fd, hz[i].dx, 1'b0, 1'b0);
            check(hz[i].name, {31'd0, pc_en}, {31'd0, !hz[i].stall});
            tick();
        end

        // Taken branch outranks a load-use
        apply(1'b0, w_add351, w_lw5, 1'b1, 1'b0);
        check("br_prio", {29'd0, pc_en, fd_bubble, dx_bubble}, 32'b111);
        tick();

        // Multiply: result arrives on the 34th cycle after the start cycle
        apply(1'b1, NOP, NOP, 1'b0, 1'b0);
        tick();
        n_start = 0; n_wait = 0; n_xmb = 0; n_stall = 0;
        for (int k = 0; k <= 34; k++) begin
            apply(1'b0, NOP, w_mul, 1'b0, (k == 34));
            if (md_start) begin
                n_start++;
                check("mul_is_div", {31'd0, md_is_div}, 32'd0);
            end
            if (md_busy && !md_ready) n_wait++;
            if (xm_bubble) n_xmb++;
            if (!pc_en) n_stall++;
            if (k == 34) check("mul_release", {24'd0, pc_en, fd_en, dx_en, xm_en, mw_en,
                                               fd_bubble, dx_bubble, xm_bubble}, 32'hF8);
            tick();
        end
        apply(1'b0, NOP, w_add351, 1'b0, 1'b0);
        check("mul_no_restart", {31'd0, md_start}, 32'd0);
        check("mul_starts", n_start, 32'd1);
        check("mul_wait_busy", n_wait, 32'd33);
        check("mul_xm_bubble", n_xmb, 32'd34);
        check("mul_stalls", n_stall, 32'd34);
        check("mul_cnt", stall_cnt, 32'd34);
        check("mul_cnt3_sat", {29'd0, stall_cnt3}, 32'd7);
        tick();

        // Divide interrupted by reset at cycle 10, then a stale md_ready
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, NOP, w_div, 1'b0, 1'b0);
            if (k == 0) check("div_is_div", {30'd0, md_start, md_is_div}, 32'b11);
            tick();
        end
        apply(1'b1, NOP, w_div, 1'b0, 1'b0);
        check("div_rst_busy", {31'd0, md_busy}, 32'd0);
        tick();
        apply(1'b0, NOP, NOP, 1'b0, 1'b1);
        check("late_ready", {27'd0, md_busy, md_start, pc_en, xm_bubble, dx_en}, 32'b00101);
        check("late_cnt", stall_cnt, 32'd0);
        tick();
        apply(1'b0, w_add351, NOP, 1'b0, 1'b0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
